// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file constants and index/data types
package cpu_pkg;

    localparam int NREGS  = 16;
    localparam int REG_AW = 4;
    localparam int DW     = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [DW-1:0]     data_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - issue, result-stream and write-port bundle for the write-back controller
// slave modport: the write-back controller; master modport: decode/execute/memory side driving it.
//   issue_*      decode presents an instruction, gets issue_stall back
//   alu_*/mem_*  result streams (valid/ready), ready is the grant
//   rf_*         registered register-file write port
//   busy         any register still awaiting write-back
interface regfile_wb_arbiter_if;

    logic              issue_valid;
    logic              issue_wr;
    cpu_pkg::reg_idx_t issue_rd;
    cpu_pkg::reg_idx_t issue_rs1;
    cpu_pkg::reg_idx_t issue_rs2;
    logic              issue_stall;

    logic              alu_valid;
    cpu_pkg::reg_idx_t alu_rd;
    cpu_pkg::data_t    alu_data;
    logic              alu_ready;

    logic              mem_valid;
    cpu_pkg::reg_idx_t mem_rd;
    cpu_pkg::data_t    mem_data;
    logic              mem_ready;

    logic              rf_we;
    cpu_pkg::reg_idx_t rf_rd;
    cpu_pkg::data_t    rf_wdata;
    logic              busy;

    modport slave (
        input  issue_valid, issue_wr, issue_rd, issue_rs1, issue_rs2,
        output issue_stall,
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output rf_we, rf_rd, rf_wdata, busy
    );

    modport master (
        output issue_valid, issue_wr, issue_rd, issue_rs1, issue_rs2,
        input  issue_stall,
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  rf_we, rf_rd, rf_wdata, busy
    );

endinterface

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-write bit per register with set/clear and three lookups
// Ports: clk, rst_n (async, active low); set_en/set_idx marks a register pending,
// clr_en/clr_idx retires it; rs1/rs2/rd lookups return the current pending bit; busy = any pending.
module wb_scoreboard
    import cpu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t rs1_idx,
    input  reg_idx_t rs2_idx,
    input  reg_idx_t rd_idx,
    output logic     rs1_hit,
    output logic     rs2_hit,
    output logic     rd_hit,
    output logic     busy
);

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;

    // Clear is applied before set so a same-edge set of the same index wins.
    // r0 can never be pending.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) pending_nxt[clr_idx] = 1'b0;
        if (set_en) pending_nxt[set_idx] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nxt;
    end

    assign rs1_hit = pending[rs1_idx];
    assign rs2_hit = pending[rs2_idx];
    assign rd_hit  = pending[rd_idx];
    assign busy    = |pending;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/load write-back arbiter with registered RF write port and hazard stall
// Ports: clk, rst_n (async, active low), wb (slave modport): issue_* in / issue_stall out,
// alu_*/mem_* result streams in with *_ready out, rf_we/rf_rd/rf_wdata registered out, busy out.
module regfile_wb_arbiter
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  wb
);

    logic     rr_alu;        // 1: ALU wins the next contested cycle
    logic     grant_alu;
    logic     grant_mem;
    logic     contested;
    reg_idx_t wb_rd;
    data_t    wb_data;
    logic     issue_accept;
    logic     rs1_hit;
    logic     rs2_hit;
    logic     rd_hit;
    logic     sb_busy;
    logic     rf_we_q;
    reg_idx_t rf_rd_q;
    data_t    rf_wdata_q;

    // Grants are gated by rst_n so a requester sees no ready while reset is held.
    always_comb begin
        contested = wb.alu_valid & wb.mem_valid;
        grant_alu = rst_n & wb.alu_valid & (~wb.mem_valid | rr_alu);
        grant_mem = rst_n & wb.mem_valid & (~wb.alu_valid | ~rr_alu);
        wb_rd     = grant_mem ? wb.mem_rd   : wb.alu_rd;
        wb_data   = grant_mem ? wb.mem_data : wb.alu_data;
    end

    assign wb.alu_ready   = grant_alu;
    assign wb.mem_ready   = grant_mem;
    assign wb.issue_stall = wb.issue_valid & (rs1_hit | rs2_hit | (wb.issue_wr & rd_hit));
    assign issue_accept   = wb.issue_valid & ~wb.issue_stall & wb.issue_wr & (wb.issue_rd != '0);

    wb_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (issue_accept),
        .set_idx (wb.issue_rd),
        .clr_en  (rf_we_q),
        .clr_idx (rf_rd_q),
        .rs1_idx (wb.issue_rs1),
        .rs2_idx (wb.issue_rs2),
        .rd_idx  (wb.issue_rd),
        .rs1_hit (rs1_hit),
        .rs2_hit (rs2_hit),
        .rd_hit  (rd_hit),
        .busy    (sb_busy)
    );

    // A granted r0 result completes its handshake but never reaches the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_alu     <= 1'b1;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= (grant_alu | grant_mem) & (wb_rd != '0);
            if ((grant_alu | grant_mem) && (wb_rd != '0)) begin
                rf_rd_q    <= wb_rd;
                rf_wdata_q <= wb_data;
            end
            if (contested) rr_alu <= grant_mem;
        end
    end

    assign wb.rf_we    = rf_we_q;
    assign wb.rf_rd    = rf_rd_q;
    assign wb.rf_wdata = rf_wdata_q;
    assign wb.busy     = sb_busy;

endmodule
